// File: rtl/cnn_accel_shell.sv
// Memory-mapped front-end of the one-layer CNN accelerator: buffers weights, biases and pixels,
// sequences the external compute core and serves status reads. Define PIXEL_PINGPONG_EN for two pixel banks.
module cnn_accel_shell #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned WEIGHT_DEPTH = 792,
    parameter int unsigned BIAS_DEPTH   = 16,
    parameter int unsigned PIXEL_DEPTH  = 3072,
    parameter logic [31:0] DONE_CODE    = 32'h1111_1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       awaddr,
    input  logic              awvalid,
    input  logic [31:0]       wdata,
    input  logic              wvalid,
    input  logic [31:0]       araddr,
    input  logic              arvalid,
    output logic [31:0]       rdata,
    output logic              interrupt_signal,
    output logic              core_start,
    output logic              core_bank,
    input  logic              core_done,
    input  logic [9:0]        w_raddr,
    input  logic [3:0]        b_raddr,
    input  logic [11:0]       p_raddr,
    output logic [DATA_W-1:0] w_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] p_rdata
);

`ifdef PIXEL_PINGPONG_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif

    localparam int unsigned WPTR_W  = $clog2(WEIGHT_DEPTH + 1);
    localparam int unsigned WADDR_W = $clog2(WEIGHT_DEPTH);
    localparam int unsigned BPTR_W  = $clog2(BIAS_DEPTH + 1);
    localparam int unsigned BADDR_W = $clog2(BIAS_DEPTH);
    localparam int unsigned PPTR_W  = $clog2(PIXEL_DEPTH);
    localparam int unsigned PIX_AW  = $clog2(NBANK * PIXEL_DEPTH);
    localparam int unsigned CNT_W   = 6;

    localparam logic [15:0] PAGE_WEIGHT = 16'hD333;
    localparam logic [15:0] PAGE_BIAS   = 16'hD444;
    localparam logic [15:0] PAGE_PIXEL  = 16'hD555;
    localparam logic [31:0] ADDR_RESULT = 32'hD000_0000;
    localparam logic [31:0] ADDR_COUNT  = 32'hD111_0000;
    localparam logic [31:0] ADDR_IRQ    = 32'hD222_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [WPTR_W-1:0]   wptr_q, wptr_d;
    logic [BPTR_W-1:0]   bptr_q, bptr_d;
    logic [PPTR_W-1:0]   pptr_q, pptr_d;
    logic                wr_bank_q, wr_bank_d;
    logic                cmp_bank_q, cmp_bank_d;
    logic                cur_bank_q, cur_bank_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic                start_q, start_d;
    logic                irq_q, irq_d;
    logic                sticky_q, sticky_d;
    logic [31:0]         result_q, result_d;
    logic [CNT_W-1:0]    pics_q, pics_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [DATA_W-1:0] weight_mem [WEIGHT_DEPTH];
    logic [DATA_W-1:0] bias_mem   [BIAS_DEPTH];
    logic [DATA_W-1:0] pix_mem    [NBANK * PIXEL_DEPTH];

    logic wr_weight, wr_bias, wr_pixel, clr_sticky;
    logic pix_last, weights_full, biases_full, done_evt;
    logic unused_bits;

    // Banks are laid out back to back in one flat array.
    function automatic logic [PIX_AW-1:0] pix_index(input logic bank, input logic [PPTR_W-1:0] ptr);
        return PIX_AW'(32'(ptr) + (bank ? PIXEL_DEPTH : 32'd0));
    endfunction

    assign unused_bits  = ^{awvalid, wdata[31:DATA_W]};
    assign weights_full = (wptr_q == WPTR_W'(WEIGHT_DEPTH));
    assign biases_full  = (bptr_q == BPTR_W'(BIAS_DEPTH));
    assign pix_last     = (pptr_q == PPTR_W'(PIXEL_DEPTH - 1));
    assign done_evt     = (state_q == ST_RUN) && core_done;
    assign clr_sticky   = wvalid && (awaddr == ADDR_IRQ);
    assign wr_weight    = wvalid && (awaddr[31:16] == PAGE_WEIGHT) && !weights_full;
    assign wr_bias      = wvalid && (awaddr[31:16] == PAGE_BIAS) && !biases_full;
`ifdef PIXEL_PINGPONG_EN
    assign wr_pixel     = wvalid && (awaddr[31:16] == PAGE_PIXEL) && !bank_full_q[wr_bank_q];
`else
    assign wr_pixel     = wvalid && (awaddr[31:16] == PAGE_PIXEL) && !bank_full_q[wr_bank_q]
                          && (state_q == ST_IDLE);
`endif

    // Local memories: written from the bus, read combinationally by the core.
    always_ff @(posedge clk) begin
        if (wr_weight) weight_mem[WADDR_W'(wptr_q)] <= wdata[DATA_W-1:0];
        if (wr_bias)   bias_mem[BADDR_W'(bptr_q)]   <= wdata[DATA_W-1:0];
        if (wr_pixel)  pix_mem[pix_index(wr_bank_q, pptr_q)] <= wdata[DATA_W-1:0];
    end

    assign w_rdata = (32'(w_raddr) < WEIGHT_DEPTH) ? weight_mem[WADDR_W'(w_raddr)] : '0;
    assign b_rdata = (32'(b_raddr) < BIAS_DEPTH)   ? bias_mem[BADDR_W'(b_raddr)]   : '0;
    assign p_rdata = (32'(p_raddr) < PIXEL_DEPTH)
                     ? pix_mem[pix_index(cur_bank_q, PPTR_W'(p_raddr))] : '0;

    // Controller: start the core on the oldest full bank once coefficients are loaded.
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        irq_d      = 1'b0;
        cur_bank_d = cur_bank_q;
        cmp_bank_d = cmp_bank_q;
        case (state_q)
            ST_IDLE: begin
                if (weights_full && biases_full && bank_full_q[cmp_bank_q]) begin
                    state_d    = ST_RUN;
                    start_d    = 1'b1;
                    cur_bank_d = cmp_bank_q;
`ifdef PIXEL_PINGPONG_EN
                    cmp_bank_d = ~cmp_bank_q;
`endif
                end
            end
            ST_RUN: begin
                if (core_done) begin
                    state_d = ST_DONE;
                    irq_d   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pointers, bank flags, status registers and read data.
    always_comb begin
        wptr_d      = wptr_q;
        bptr_d      = bptr_q;
        pptr_d      = pptr_q;
        wr_bank_d   = wr_bank_q;
        bank_full_d = bank_full_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        pics_d      = pics_q;
        rdata_d     = rdata_q;

        if (wr_weight) wptr_d = wptr_q + WPTR_W'(1);
        if (wr_bias)   bptr_d = bptr_q + BPTR_W'(1);
        if (wr_pixel) begin
            if (pix_last) begin
                pptr_d = '0;
`ifdef PIXEL_PINGPONG_EN
                wr_bank_d = ~wr_bank_q;
`endif
            end else begin
                pptr_d = pptr_q + PPTR_W'(1);
            end
        end

        // Freeing the computed bank and completing the other can coincide.
        if (done_evt)             bank_full_d[cur_bank_q] = 1'b0;
        if (wr_pixel && pix_last) bank_full_d[wr_bank_q]  = 1'b1;

        if (arvalid) begin
            case (araddr)
                ADDR_RESULT: rdata_d = result_q;
                ADDR_COUNT:  rdata_d = {26'b0, pics_q};
                ADDR_IRQ:    rdata_d = {31'b0, sticky_q};
                default:     rdata_d = '0;
            endcase
        end
        if (arvalid && (araddr == ADDR_RESULT)) result_d = '0;
        if (clr_sticky) sticky_d = 1'b0;

        // Completion overrides a coincident sticky clear or result read.
        if (done_evt) begin
            sticky_d = 1'b1;
            result_d = DONE_CODE;
            pics_d   = pics_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            bptr_q      <= '0;
            pptr_q      <= '0;
            wr_bank_q   <= 1'b0;
            cmp_bank_q  <= 1'b0;
            cur_bank_q  <= 1'b0;
            bank_full_q <= '0;
            start_q     <= 1'b0;
            irq_q       <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= '0;
            pics_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            bptr_q      <= bptr_d;
            pptr_q      <= pptr_d;
            wr_bank_q   <= wr_bank_d;
            cmp_bank_q  <= cmp_bank_d;
            cur_bank_q  <= cur_bank_d;
            bank_full_q <= bank_full_d;
            start_q     <= start_d;
            irq_q       <= irq_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            pics_q      <= pics_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata            = rdata_q;
    assign interrupt_signal = irq_q;
    assign core_start       = start_q;
`ifdef PIXEL_PINGPONG_EN
    assign core_bank        = cur_bank_q;
`else
    assign core_bank        = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_accel_shell.sv
// Directed self-checking bench for cnn_accel_shell; expected values are hand-derived from the data patterns below.
module tb_cnn_accel_shell;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic [31:0] wdata;
    logic        wvalid;
    logic [31:0] araddr;
    logic        arvalid;
    logic [31:0] rdata;
    logic        interrupt_signal;
    logic        core_start;
    logic        core_bank;
    logic        core_done;
    logic [9:0]  w_raddr;
    logic [3:0]  b_raddr;
    logic [11:0] p_raddr;
    logic [15:0] w_rdata;
    logic [15:0] b_rdata;
    logic [15:0] p_rdata;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   start_cnt = 0;
    int   irq_cnt   = 0;
    logic last_bank = 1'b0;

`ifdef PIXEL_PINGPONG_EN
    localparam logic EXP_BANK2 = 1'b1;
`else
    localparam logic EXP_BANK2 = 1'b0;
`endif

    cnn_accel_shell dut (
        .clk              (clk),
        .rst              (rst),
        .awaddr           (awaddr),
        .awvalid          (awvalid),
        .wdata            (wdata),
        .wvalid           (wvalid),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .rdata            (rdata),
        .interrupt_signal (interrupt_signal),
        .core_start       (core_start),
        .core_bank        (core_bank),
        .core_done        (core_done),
        .w_raddr          (w_raddr),
        .b_raddr          (b_raddr),
        .p_raddr          (p_raddr),
        .w_rdata          (w_rdata),
        .b_rdata          (b_rdata),
        .p_rdata          (p_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            last_bank <= core_bank;
        end
        if (interrupt_signal) irq_cnt <= irq_cnt + 1;
    end

    // Data patterns: 0..3 pixel sets, 4/5 weight sets, other values bias.
    function automatic logic [15:0] pat(input int set, input int i);
        case (set)
            0:       pat = 16'(i * 7 + 1);
            1:       pat = 16'(i * 11 + 3) ^ 16'h8000;
            2:       pat = 16'(i * 13 + 5) ^ 16'h4000;
            3:       pat = 16'(i * 17 + 9) ^ 16'h2000;
            4:       pat = 16'(i * 3 + 1) ^ 16'h5A00;
            5:       pat = 16'(i * 5 + 2) ^ 16'h7700;
            default: pat = 16'(i) ^ 16'hB000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input int gap);
        awaddr  = a;
        wdata   = d;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check(tag, rdata, exp);
    endtask

    task automatic load_pixels(input int set, input int count, input int gap);
        for (int i = 0; i < count; i++) wr(32'hD555_0000, {16'hFFFF, pat(set, i)}, gap);
    endtask

    initial begin
        rst       = 1'b0;
        awaddr    = '0;
        awvalid   = 1'b0;
        wdata     = '0;
        wvalid    = 1'b0;
        araddr    = '0;
        arvalid   = 1'b0;
        core_done = 1'b0;
        w_raddr   = '0;
        b_raddr   = '0;
        p_raddr   = '0;
        repeat (3) tick();
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(interrupt_signal), 32'h0);
        check("reset_start", 32'(core_start), 32'h0);
        rst = 1'b1;
        tick();
        rd_check("rd_count_init", 32'hD111_0000, 32'h0);
        rd_check("rd_result_init", 32'hD000_0000, 32'h0);
        check("irq_idle", 32'(interrupt_signal), 32'h0);

        // Writes that must have no effect: strobe low, unmapped page.
        awaddr = 32'hD555_0000;
        wdata  = 32'h0000_DEAD;
        tick();
        wr(32'hD666_0000, 32'h0000_BEEF, 0);

        // First picture, one word every five cycles.
        for (int i = 0; i < 792; i++) wr(32'hD333_0000, {16'hFFFF, pat(4, i)}, 4);
        for (int i = 0; i < 16; i++)  wr(32'hD444_0000, {16'hFFFF, pat(6, i)}, 4);
        load_pixels(0, 3071, 4);
        wr(32'hD555_0000, {16'hFFFF, pat(0, 3071)}, 0);
        check("start_not_early", 32'(core_start), 32'h0);
        tick();
        check("start1_pulse", 32'(core_start), 32'h1);
        check("start1_bank", 32'(core_bank), 32'h0);
        tick();
        check("start1_single", 32'(core_start), 32'h0);
        check("start1_count", 32'(start_cnt), 32'd1);
        w_raddr = 10'd0;
        b_raddr = 4'd15;
        p_raddr = 12'd5;
        #1;
        check("w_rdata_0", 32'(w_rdata), 32'(pat(4, 0)));
        check("b_rdata_15", 32'(b_rdata), 32'(pat(6, 15)));
        check("p_rdata_5_a", 32'(p_rdata), 32'(pat(0, 5)));

        // First completion and status reads.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("irq1_high", 32'(interrupt_signal), 32'h1);
        tick();
        check("irq1_low", 32'(interrupt_signal), 32'h0);
        rd_check("rd_result_done", 32'hD000_0000, 32'h1111_1111);
        rd_check("rd_result_cleared", 32'hD000_0000, 32'h0);
        rd_check("rd_count_1", 32'hD111_0000, 32'h1);
        rd_check("rd_sticky_set", 32'hD222_0000, 32'h1);
        tick();
        check("rdata_hold", rdata, 32'h1);
        wr(32'hD222_0000, 32'h0, 0);
        rd_check("rd_sticky_clr", 32'hD222_0000, 32'h0);

        // Second picture streamed back to back.
        load_pixels(1, 3072, 0);
        repeat (2) tick();
        check("start2_count", 32'(start_cnt), 32'd2);
        check("start2_bank", 32'(last_bank), 32'(EXP_BANK2));
        p_raddr = 12'd5;
        #1;
        check("p_rdata_5_b", 32'(p_rdata), 32'(pat(1, 5)));

`ifdef PIXEL_PINGPONG_EN
        // Third picture fills the freed bank while the second computes.
        load_pixels(2, 3072, 0);
`endif
        wr(32'hD555_0000, 32'h0000_DEAD, 0);
        p_raddr = 12'd0;
        #1;
        check("p_rdata_0_kept", 32'(p_rdata), 32'(pat(1, 0)));

        // Completion coinciding with a sticky clear: completion wins.
        awaddr    = 32'hD222_0000;
        wdata     = 32'h0;
        wvalid    = 1'b1;
        core_done = 1'b1;
        tick();
        wvalid    = 1'b0;
        core_done = 1'b0;
        check("irq2_high", 32'(interrupt_signal), 32'h1);
`ifdef PIXEL_PINGPONG_EN
        tick();
        check("start3_wait", 32'(core_start), 32'h0);
        tick();
        check("start3_pulse", 32'(core_start), 32'h1);
        check("start3_bank_now", 32'(core_bank), 32'h0);
`else
        tick();
`endif
        rd_check("rd_sticky_wins", 32'hD222_0000, 32'h1);
        rd_check("rd_count_2", 32'hD111_0000, 32'h2);
        check("irq_count_2", 32'(irq_cnt), 32'd2);
`ifndef PIXEL_PINGPONG_EN
        load_pixels(2, 3072, 0);
        repeat (2) tick();
`endif
        check("start3_count", 32'(start_cnt), 32'd3);
        check("start3_bank", 32'(last_bank), 32'h0);
        p_raddr = 12'd5;
        #1;
        check("p_rdata_5_c", 32'(p_rdata), 32'(pat(2, 5)));

        // Asynchronous reset while the core is running.
        rd_check("rd_count_pre_rst", 32'hD111_0000, 32'h2);
        #2;
        rst = 1'b0;
        #1;
        check("rst_rdata_async", rdata, 32'h0);
        check("rst_irq_async", 32'(interrupt_signal), 32'h0);
        check("rst_start_async", 32'(core_start), 32'h0);
        check("rst_bank_async", 32'(core_bank), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rd_check("rd_count_after_rst", 32'hD111_0000, 32'h0);
        rd_check("rd_result_after_rst", 32'hD000_0000, 32'h0);
        rd_check("rd_sticky_after_rst", 32'hD222_0000, 32'h0);

        // Reload: pixels first, 800 weights (last 8 dropped), biases last.
        load_pixels(3, 3072, 0);
        for (int i = 0; i < 800; i++) wr(32'hD333_0000, {16'hFFFF, pat(5, i)}, 0);
        for (int i = 0; i < 15; i++)  wr(32'hD444_0000, {16'hFFFF, pat(6, i)}, 0);
        tick();
        check("no_start_wo_bias", 32'(start_cnt), 32'd3);
        wr(32'hD444_0000, {16'hFFFF, pat(6, 15)}, 0);
        check("start4_not_early", 32'(core_start), 32'h0);
        tick();
        check("start4_pulse", 32'(core_start), 32'h1);
        check("start4_bank", 32'(core_bank), 32'h0);
        w_raddr = 10'd791;
        b_raddr = 4'd3;
        p_raddr = 12'd5;
        #1;
        check("w_rdata_791_sat", 32'(w_rdata), 32'(pat(5, 791)));
        check("b_rdata_3", 32'(b_rdata), 32'(pat(6, 3)));
        check("p_rdata_5_d", 32'(p_rdata), 32'(pat(3, 5)));
        tick();
        check("start4_count", 32'(start_cnt), 32'd4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
